// File: rtl/ft_arb_pkg.sv
// Shared tags, state encoding and framing helper for the FT600 TX arbiter.
// Frame word layout: tag[15:12], channel[11:8], count[7:0].
package ft_arb_pkg;

    localparam logic [3:0] TAG_HDR     = 4'hA;
    localparam logic [3:0] TAG_TRL     = 4'h5;
    localparam logic [3:0] TAG_TRL_CKS = 4'h6;

    localparam int TAG_MSB = 15;
    localparam int TAG_LSB = 12;
    localparam int CH_MSB  = 11;
    localparam int CH_LSB  = 8;
    localparam int CNT_MSB = 7;
    localparam int CNT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        TRL,
        CKS
    } state_t;

    function automatic logic [15:0] frame_word(
        input logic [3:0] tag,
        input logic [3:0] ch,
        input logic [7:0] cnt
    );
        logic [15:0] w;
        w = '0;
        w[TAG_MSB:TAG_LSB] = tag;
        w[CH_MSB:CH_LSB]   = ch;
        w[CNT_MSB:CNT_LSB] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ft600_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int PW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [PW-1:0]     gnt_idx,
    output logic              any_req
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any_req && req[(int'(ptr) + i) % NUM_CH]) begin
                any_req = 1'b1;
                gnt_idx = PW'((int'(ptr) + i) % NUM_CH);
            end
        end
        gnt_oh[gnt_idx] = any_req;
    end

endmodule

// File: rtl/ft600_tx_arbiter.sv
// Round-robin framer sharing the FT600 TX FIFO port between NUM_CH streams.
// Define FT_ARB_CHECKSUM_EN to append an XOR checksum word after each trailer.
module ft600_tx_arbiter
    import ft_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [16*NUM_CH-1:0] req_data,
    input  logic [NUM_CH-1:0]    req_last,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic                 tx_full,
    output logic                 tx_en,
    output logic [15:0]          tx_in,
    output logic                 busy
);

    localparam int PW = $clog2(NUM_CH);
`ifdef FT_ARB_CHECKSUM_EN
    localparam logic [3:0] TRL_TAG = TAG_TRL_CKS;
`else
    localparam logic [3:0] TRL_TAG = TAG_TRL;
`endif

    state_t            state_q, state_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] goh_q, goh_d;
    logic [7:0]        count_q, count_d;
`ifdef FT_ARB_CHECKSUM_EN
    logic [15:0]       acc_q, acc_d;
`endif

    logic [NUM_CH-1:0] arb_oh;
    logic [PW-1:0]     arb_idx;
    logic              arb_any;
    logic              g_valid, g_last, xfer;
    logic [15:0]       g_data;
    logic [3:0]        ch4;
    logic [PW-1:0]     ptr_next;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    assign g_valid  = |(req_valid & goh_q);
    assign g_last   = |(req_last & goh_q);
    assign g_data   = req_data[int'(grant_q)*16 +: 16];
    assign ch4      = 4'(grant_q);
    assign ptr_next = (grant_q == PW'(NUM_CH - 1)) ? '0 : grant_q + PW'(1);
    assign xfer     = tx_en & ~tx_full;
    assign busy     = (state_q != IDLE);

    always_comb begin
        tx_en     = 1'b0;
        tx_in     = '0;
        req_ready = '0;
        unique case (state_q)
            HDR: begin
                tx_en = 1'b1;
                tx_in = frame_word(TAG_HDR, ch4, 8'h00);
            end
            PAY: begin
                req_ready = goh_q & {NUM_CH{~tx_full}};
                tx_en     = g_valid;
                tx_in     = g_valid ? g_data : '0;
            end
            TRL: begin
                tx_en = 1'b1;
                tx_in = frame_word(TRL_TAG, ch4, count_q);
            end
`ifdef FT_ARB_CHECKSUM_EN
            CKS: begin
                tx_en = 1'b1;
                tx_in = acc_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        goh_d    = goh_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
`ifdef FT_ARB_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        unique case (state_q)
            IDLE: if (arb_any) begin
                grant_d = arb_idx;
                goh_d   = arb_oh;
                state_d = HDR;
            end
            HDR: begin
`ifdef FT_ARB_CHECKSUM_EN
                acc_d = '0;
`endif
                if (xfer) begin
                    count_d = '0;
                    state_d = PAY;
                end
            end
            PAY: if (xfer) begin
                count_d = count_q + 8'd1;
`ifdef FT_ARB_CHECKSUM_EN
                acc_d = acc_q ^ tx_in;
`endif
                if (g_last || (count_q + 8'd1 == 8'(BURST_MAX)))
                    state_d = TRL;
            end
            TRL: if (xfer) begin
`ifdef FT_ARB_CHECKSUM_EN
                state_d = CKS;
`else
                rr_ptr_d = ptr_next;
                state_d  = IDLE;
`endif
            end
            CKS: if (xfer) begin
                rr_ptr_d = ptr_next;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            goh_q    <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
`ifdef FT_ARB_CHECKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            goh_q    <= goh_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
`ifdef FT_ARB_CHECKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: doc/ft600_tx_arbiter.md
Name: ft600_tx_arbiter

Overview:
- Shares the single FT600 245-mode TX FIFO write port (tx_en / tx_in / tx_full) between NUM_CH independent 16-bit word streams.
- Grants channels round-robin and frames each burst with a header word and a trailer word, so the host can demultiplex the USB stream.
- Sits in the clk domain between the data producers and ft600_mode245.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- BURST_MAX, 16, maximum payload words per burst (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_CH  channel c has a payload word on req_data.
- req_data  in  16*NUM_CH  channel c word is at bits [16c+15:16c].
- req_last  in  NUM_CH  current word of channel c ends its packet.
- req_ready  out  NUM_CH  word of channel c is accepted this cycle.
- tx_full  in  1  full flag from the FT600 TX FIFO.
- tx_en  out  1  write strobe to the FT600 TX FIFO.
- tx_in  out  16  write data to the FT600 TX FIFO.
- busy  out  1  a burst is in progress (state is not IDLE).

Behaviour:
- Transfer rule: a word is written to the FIFO exactly on a cycle with tx_en=1 and tx_full=0.
  - tx_en and tx_in are combinational from registered state and the granted channel.
  - tx_in=0 whenever tx_en=0.
  - The block never deasserts tx_en while tx_full=1 with an unaccepted header or trailer word; it holds that word.
- Reset: state=IDLE, rr_ptr=0, grant=0, count=0; tx_en=0, tx_in=0, req_ready=0, busy=0.
- Reset mid-burst aborts immediately. No trailer is emitted, and the partial burst is the host's problem.
- State IDLE:
  - If any req_valid is high, register grant = first valid channel at or after rr_ptr, cyclically.
  - Next state HDR. A grant costs 1 cycle; tx_en=0 in IDLE.
- State HDR:
  - tx_en=1, tx_in = {4'hA, 4'(grant), 8'h00}.
  - On transfer: count=0, next state PAY.
- State PAY:
  - req_ready[grant] = ~tx_full; all other req_ready bits are 0.
  - tx_en = req_valid[grant], tx_in = granted word.
  - On transfer: count++.
  - Leave to TRL when the transferred word has req_last=1, or when count reaches BURST_MAX.
  - If valid drops, wait in PAY indefinitely with tx_en=0.
- State TRL:
  - tx_en=1, tx_in = {4'h5, 4'(grant), 8'(count)}.
  - On transfer: rr_ptr = (grant+1) mod NUM_CH, next state IDLE.
- Width and wrap rules:
  - count is 8 bits and never exceeds BURST_MAX.
  - rr_ptr wraps from NUM_CH-1 to 0.
- A packet longer than BURST_MAX is split into multiple bursts. Only the burst containing req_last ends the packet, and other channels may interleave between bursts.
- Simultaneous requests are resolved purely by rr_ptr. Requests arriving during a burst wait for IDLE.
- busy=1 in HDR, PAY and TRL.

Optional Feature:
- Macro FT_ARB_CHECKSUM_EN.
- Defined:
  - A 16-bit XOR accumulator clears in HDR and XORs in each transferred payload word.
  - After the trailer transfers, state CKS presents tx_in = accumulator under the same full-hold rule, then goes to IDLE.
  - rr_ptr updates on the CKS transfer.
  - The trailer tag becomes 4'h6 to mark that a checksum follows.
- Undefined: no CKS state, trailer tag is 4'h5, and the accumulator logic is absent.

Decomposition:
- Package ft_arb_pkg holds:
  - tag constants TAG_HDR=4'hA, TAG_TRL=4'h5, TAG_TRL_CKS=4'h6;
  - state enum IDLE, HDR, PAY, TRL, CKS;
  - header/trailer field positions.
- Sub-module rr_arbiter(NUM_CH): combinational one-hot and index grant from the req vector and rr_ptr, plus an any-request flag.

Test Plan:
- Single channel: ch1 sends 3 words 0x1111, 0x2222, 0x3333 (last on the third), tx_full=0 → FIFO receives A100, 1111, 2222, 3333, 5103.
- Round-robin: ch0 and ch2 are both valid with 1-word packets, rr_ptr=0 → bursts in order ch0, ch2; rr_ptr then equals 3. Re-request both → next order is ch0, ch2 again, since ch3 is idle.
- Burst split: ch3 streams 20 words with last on word 20, BURST_MAX=16 → A300, 16 words, 5310, then after re-arbitration A300, 4 words, 5304.
- Backpressure: tx_full=1 for 5 cycles during HDR and for 3 cycles mid-PAY → words are held stable, req_ready stays 0 while full, and there are no duplicates or drops in the FIFO log.
- Reset mid-PAY after 2 words → next cycle tx_en=0, busy=0, rr_ptr=0. The next request from ch2 starts with a fresh header A200.
- With FT_ARB_CHECKSUM_EN, ch0 sends 0x00FF, 0x0F0F (last) → A000, 00FF, 0F0F, 6002, 0FF0.
